r_pow_mac_x_t: RTL

Multiply-accumulate stage that consumes the T-lane power vectors r_j^i (one 32-bit GF(2^32) element per evaluation point) produced by the power-exponentiation stage. It computes, for every lane j, acc_j = XOR over i of (c_i · r_j^i) across a streamed sequence of coefficient/power pairs. The result is the T polynomial evaluations P(r_j) needed by the downstream consistency check. A single internal gf_mul_32 is time-shared across the lanes, and all arithmetic is constant-time.

---
 rtl/r_pow_mac_x_t.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/r_pow_mac_x_t.sv
// Multiply-accumulate of T-lane GF(2^32) power vectors against streamed coefficients.
// One bit-serial multiplier is time-shared across lanes; timing is data-independent.
module gf_mul_32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic        done,
    output logic [31:0] p
);
    // Field polynomial x^32 + x^7 + x^3 + x^2 + 1, low 32 bits.
    localparam logic [31:0] POLY = 32'h0000_008D;

    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  cnt;
    logic        run;

    // MSB-first Horner: p = p*x mod f, then add a if the next bit of b is set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a    <= '0;
            b    <= '0;
            p    <= '0;
            cnt  <= '0;
            run  <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                a   <= x;
                b   <= y;
                p   <= '0;
                cnt <= '0;
                run <= 1'b1;
            end else if (run) begin
                p   <= {p[30:0], 1'b0} ^ (p[31] ? POLY : 32'h0) ^ (b[31] ? a : 32'h0);
                b   <= {b[30:0], 1'b0};
                cnt <= cnt + 5'd1;
                if (cnt == 5'd31) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end
endmodule

module r_pow_mac_x_t #(
    parameter int M = 230,
    parameter int T = 3
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic [$clog2(M+1)-1:0] i_len,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [31:0]            i_coef,
    input  logic [32*T-1:0]        i_pow,
    output logic [32*T-1:0]        o_acc,
    output logic                   o_busy,
    output logic                   o_done
);
    localparam int LW = $clog2(M + 1);
    localparam int NW = (T > 1) ? $clog2(T) : 1;

    typedef enum logic [2:0] {
        IDLE, WAIT_IN, MUL_START, MUL_WAIT, DONE
    } state_t;

    state_t          state;
    state_t          next;
    logic [32*T-1:0] acc;
    logic [32*T-1:0] pow;
    logic [31:0]     coef;
    logic [LW-1:0]   cnt;
    logic [LW-1:0]   len;
    logic [NW-1:0]   lane;
    logic            mul_start;
    logic            mul_done;
    logic [31:0]     prod;
    logic            last_lane;
    logic            last_term;

    assign last_lane = (lane == NW'(T - 1));
    assign last_term = (cnt == len - LW'(1));

    gf_mul_32 u_mul (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .start (mul_start),
        .x     (coef),
        .y     (pow[32*lane +: 32]),
        .done  (mul_done),
        .p     (prod)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= next;
    end

    always_comb begin
        next = state;
        unique case (state)
            IDLE:      if (i_start) next = (i_len == '0) ? DONE : WAIT_IN;
            WAIT_IN:   if (i_valid) next = MUL_START;
            MUL_START: next = MUL_WAIT;
            MUL_WAIT:
                if (mul_done) begin
                    if (!last_lane)     next = MUL_START;
                    else if (last_term) next = DONE;
                    else                next = WAIT_IN;
                end
            DONE:      next = IDLE;
            default:   next = IDLE;
        endcase
    end

    always_comb begin
        o_ready   = (state == WAIT_IN);
        o_busy    = (state != IDLE);
        o_done    = (state == DONE);
        mul_start = (state == MUL_START);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            acc  <= '0;
            pow  <= '0;
            coef <= '0;
            cnt  <= '0;
            len  <= '0;
            lane <= '0;
        end else begin
            if (state == IDLE && i_start) begin
                acc <= '0;
                cnt <= '0;
                len <= i_len;
            end
            if (state == WAIT_IN && i_valid) begin
                coef <= i_coef;
                pow  <= i_pow;
                lane <= '0;
            end
            if (state == MUL_WAIT && mul_done) begin
                acc[32*lane +: 32] <= acc[32*lane +: 32] ^ prod;
                if (last_lane) cnt  <= cnt + LW'(1);
                else           lane <= lane + NW'(1);
            end
        end
    end

    assign o_acc = acc;
endmodule
